l2_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one wide-to-word serializer port between NUM_REQS wide memory requesters on the L2 bus-adapter side.
- Accepts one request at a time, registers it and drives it to the serializer.
- For reads, captures the single response and routes it back to the owning requester.
- Writes complete on the serializer request handshake; no response is generated.

---
 rtl/l2_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_l2_bus_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter sharing one serializer port between NUM_REQS wide requesters.
// One transaction in flight at a time; reads return a single response to the owner.
module l2_bus_arbiter #(
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned ADDR_WIDTH_BIT = 26,
  parameter int unsigned DATA_WIDTH_BIT = 128,
  parameter int unsigned TAG_WIDTH_BIT  = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_REQS-1:0]                    in_req_valid_i,
  input  logic [NUM_REQS-1:0]                    in_req_rw_i,
  input  logic [NUM_REQS*DATA_WIDTH_BIT/8-1:0]   in_req_byteen_i,
  input  logic [NUM_REQS*ADDR_WIDTH_BIT-1:0]     in_req_addr_i,
  input  logic [NUM_REQS*DATA_WIDTH_BIT-1:0]     in_req_data_i,
  input  logic [NUM_REQS*TAG_WIDTH_BIT-1:0]      in_req_tag_i,
  output logic [NUM_REQS-1:0]                    in_req_ready_o,
  output logic [NUM_REQS-1:0]                    in_rsp_valid_o,
  output logic [DATA_WIDTH_BIT-1:0]              in_rsp_data_o,
  output logic [TAG_WIDTH_BIT-1:0]               in_rsp_tag_o,
  input  logic [NUM_REQS-1:0]                    in_rsp_ready_i,
  output logic                                   out_req_valid_o,
  input  logic                                   out_req_ready_i,
  output logic                                   out_req_rw_o,
  output logic [DATA_WIDTH_BIT/8-1:0]            out_req_byteen_o,
  output logic [ADDR_WIDTH_BIT-1:0]              out_req_addr_o,
  output logic [DATA_WIDTH_BIT-1:0]              out_req_data_o,
  output logic [TAG_WIDTH_BIT-1:0]               out_req_tag_o,
  input  logic                                   out_rsp_valid_i,
  output logic                                   out_rsp_ready_o,
  input  logic [DATA_WIDTH_BIT-1:0]              out_rsp_data_i,
  input  logic [TAG_WIDTH_BIT-1:0]               out_rsp_tag_i,
  output logic [$clog2(NUM_REQS)-1:0]            grant_idx_o,
  output logic                                   busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQS);
  localparam int unsigned BeW  = DATA_WIDTH_BIT / 8;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSendReq = 2'd1;
  localparam logic [1:0] StWaitRsp = 2'd2;
  localparam logic [1:0] StSendRsp = 2'd3;

  localparam logic [NUM_REQS-1:0] OneHot0 = {{(NUM_REQS-1){1'b0}}, 1'b1};

  logic [1:0]                state_q, state_d;
  logic [IdxW-1:0]           ptr_q, grant_q;
  logic                      armed_q;
  logic                      rw_q;
  logic [BeW-1:0]            be_q;
  logic [ADDR_WIDTH_BIT-1:0] addr_q;
  logic [DATA_WIDTH_BIT-1:0] data_q;
  logic [TAG_WIDTH_BIT-1:0]  tag_q;
  logic [DATA_WIDTH_BIT-1:0] rsp_data_q;
  logic [TAG_WIDTH_BIT-1:0]  rsp_tag_q;

  logic                      active;
  logic                      found;
  logic [IdxW-1:0]           win, cand, ptr_nxt;
  logic                      accept, req_hs, rsp_cap, rsp_hs;

  logic [BeW-1:0]            be_arr   [NUM_REQS];
  logic [ADDR_WIDTH_BIT-1:0] addr_arr [NUM_REQS];
  logic [DATA_WIDTH_BIT-1:0] data_arr [NUM_REQS];
  logic [TAG_WIDTH_BIT-1:0]  tag_arr  [NUM_REQS];

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_unpack
    assign be_arr[r]   = in_req_byteen_i[r*BeW +: BeW];
    assign addr_arr[r] = in_req_addr_i[r*ADDR_WIDTH_BIT +: ADDR_WIDTH_BIT];
    assign data_arr[r] = in_req_data_i[r*DATA_WIDTH_BIT +: DATA_WIDTH_BIT];
    assign tag_arr[r]  = in_req_tag_i[r*TAG_WIDTH_BIT +: TAG_WIDTH_BIT];
  end

  // Handshakes are held off during reset and for the first cycle after release.
  assign active = rst_ni & armed_q;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_REQS);
      if (!found && in_req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    ptr_nxt = (32'(win) == NUM_REQS - 1) ? '0 : win + 1'b1;
  end

  // Output decode and handshake qualification.
  always_comb begin
    accept           = active && (state_q == StIdle) && found;
    in_req_ready_o   = accept ? (OneHot0 << win) : '0;
    out_req_valid_o  = active && (state_q == StSendReq);
    out_rsp_ready_o  = active && (state_q == StWaitRsp);
    in_rsp_valid_o   = (active && (state_q == StSendRsp)) ? (OneHot0 << grant_q) : '0;
    req_hs           = out_req_valid_o & out_req_ready_i;
    rsp_cap          = out_rsp_ready_o & out_rsp_valid_i;
    rsp_hs           = active && (state_q == StSendRsp) && in_rsp_ready_i[grant_q];
    out_req_rw_o     = rw_q;
    out_req_byteen_o = be_q;
    out_req_addr_o   = addr_q;
    out_req_data_o   = data_q;
    out_req_tag_o    = tag_q;
    in_rsp_data_o    = rsp_data_q;
    in_rsp_tag_o     = rsp_tag_q;
    grant_idx_o      = grant_q;
    busy_o           = (state_q != StIdle);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept)  state_d = StSendReq;
      StSendReq: if (req_hs)  state_d = rw_q ? StIdle : StWaitRsp;
      StWaitRsp: if (rsp_cap) state_d = StSendRsp;
      StSendRsp: if (rsp_hs)  state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // State, pointer, registered request and captured response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_q    <= '0;
      armed_q    <= 1'b0;
      rw_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;
      if (accept) begin
        ptr_q   <= ptr_nxt;
        grant_q <= win;
        rw_q    <= in_req_rw_i[win];
        be_q    <= be_arr[win];
        addr_q  <= addr_arr[win];
        data_q  <= data_arr[win];
        tag_q   <= tag_arr[win];
      end
      if (rsp_cap) begin
        rsp_data_q <= out_rsp_data_i;
        rsp_tag_q  <= out_rsp_tag_i;
      end
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter: directed scenarios plus a random phase,
// all checked against a transaction-level model of the arbitration rules.
module tb_l2_bus_arbiter;

  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]          in_req_valid = '0;
  logic [3:0]          in_req_rw = '0;
  logic [3:0][15:0]    in_req_byteen = '0;
  logic [3:0][AW-1:0]  in_req_addr = '0;
  logic [3:0][DW-1:0]  in_req_data = '0;
  logic [3:0][TW-1:0]  in_req_tag = '0;
  logic [3:0]          in_req_ready_o;
  logic [3:0]          in_rsp_valid_o;
  logic [DW-1:0]       in_rsp_data_o;
  logic [TW-1:0]       in_rsp_tag_o;
  logic [3:0]          in_rsp_ready = '0;
  logic                out_req_valid_o;
  logic                out_req_ready = 1'b0;
  logic                out_req_rw_o;
  logic [15:0]         out_req_byteen_o;
  logic [AW-1:0]       out_req_addr_o;
  logic [DW-1:0]       out_req_data_o;
  logic [TW-1:0]       out_req_tag_o;
  logic                out_rsp_valid = 1'b0;
  logic                out_rsp_ready_o;
  logic [DW-1:0]       out_rsp_data = '0;
  logic [TW-1:0]       out_rsp_tag = '0;
  logic [1:0]          grant_idx_o;
  logic                busy_o;

  l2_bus_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_req_valid_i  (in_req_valid),
    .in_req_rw_i     (in_req_rw),
    .in_req_byteen_i (in_req_byteen),
    .in_req_addr_i   (in_req_addr),
    .in_req_data_i   (in_req_data),
    .in_req_tag_i    (in_req_tag),
    .in_req_ready_o  (in_req_ready_o),
    .in_rsp_valid_o  (in_rsp_valid_o),
    .in_rsp_data_o   (in_rsp_data_o),
    .in_rsp_tag_o    (in_rsp_tag_o),
    .in_rsp_ready_i  (in_rsp_ready),
    .out_req_valid_o (out_req_valid_o),
    .out_req_ready_i (out_req_ready),
    .out_req_rw_o    (out_req_rw_o),
    .out_req_byteen_o(out_req_byteen_o),
    .out_req_addr_o  (out_req_addr_o),
    .out_req_data_o  (out_req_data_o),
    .out_req_tag_o   (out_req_tag_o),
    .out_rsp_valid_i (out_rsp_valid),
    .out_rsp_ready_o (out_rsp_ready_o),
    .out_rsp_data_i  (out_rsp_data),
    .out_rsp_tag_i   (out_rsp_tag),
    .grant_idx_o     (grant_idx_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one outstanding transaction with its progress flags.
  logic [1:0]    m_ptr, m_owner;
  bit            m_armed, m_busy, m_issued, m_captured, m_rw;
  logic [15:0]   m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata;
  logic [TW-1:0] m_tag, m_rtag;

  int cyc = 0;
  int acc_q[$];
  int acc_cyc_q[$];
  int rsp_first_cyc, rsp_hs_cyc, n_rsp, req_valid_cnt, rsp_valid_cnt;
  bit rsp_seen, obs_rsp_ready;
  logic [3:0] last_rsp_valid;

  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] q;
    for (int i = 0; i < 4; i++) begin
      q = p + 2'(i);
      if (v[q]) return q;
    end
    return p;
  endfunction

  task automatic monitor();
    logic [3:0] exp_rdy, exp_rv;
    logic [1:0] w;
    bit acc, req_hs, rsp_cap, rsp_hs, req_exp, rr_exp;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check_eq("rst_req_ready", in_req_ready_o, 0);
      check_eq("rst_out_req_valid", out_req_valid_o, 0);
      check_eq("rst_out_rsp_ready", out_rsp_ready_o, 0);
      check_eq("rst_rsp_valid", in_rsp_valid_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_grant", grant_idx_o, 0);
      check_eq("rst_addr", out_req_addr_o, 0);
      return;
    end
    exp_rdy = '0;
    acc = 0;
    w = '0;
    if (m_armed && !m_busy && in_req_valid != 0) begin
      w = rr_pick(in_req_valid, m_ptr);
      exp_rdy = 4'b0001 << w;
      acc = 1;
    end
    check_eq("req_ready", in_req_ready_o, exp_rdy);
    check_eq("busy", busy_o, m_busy);
    check_eq("grant_idx", grant_idx_o, m_owner);
    req_exp = m_busy && !m_issued;
    check_eq("out_req_valid", out_req_valid_o, req_exp);
    req_hs = 0;
    if (req_exp) begin
      check_eq("out_req_rw", out_req_rw_o, m_rw);
      check_eq("out_req_be", out_req_byteen_o, m_be);
      check_eq("out_req_addr", out_req_addr_o, m_addr);
      check_eq("out_req_data", out_req_data_o, m_data);
      check_eq("out_req_tag", out_req_tag_o, m_tag);
      req_valid_cnt++;
      req_hs = out_req_ready;
    end
    rr_exp = m_busy && m_issued && !m_captured;
    obs_rsp_ready = out_rsp_ready_o;
    check_eq("out_rsp_ready", out_rsp_ready_o, rr_exp);
    rsp_cap = rr_exp && out_rsp_valid;
    exp_rv = (m_busy && m_captured) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq("rsp_valid", in_rsp_valid_o, exp_rv);
    rsp_hs = 0;
    if (exp_rv != 0) begin
      check_eq("rsp_data", in_rsp_data_o, m_rdata);
      check_eq("rsp_tag", in_rsp_tag_o, m_rtag);
      last_rsp_valid = in_rsp_valid_o;
      rsp_valid_cnt++;
      if (!rsp_seen) begin
        rsp_first_cyc = cyc;
        rsp_seen = 1;
      end
      rsp_hs = in_rsp_ready[m_owner];
    end
    if (acc) begin
      m_busy = 1; m_issued = 0; m_captured = 0; m_owner = w;
      m_rw = in_req_rw[w]; m_be = in_req_byteen[w]; m_addr = in_req_addr[w];
      m_data = in_req_data[w]; m_tag = in_req_tag[w];
      m_ptr = w + 2'd1;
      acc_q.push_back(int'(w));
      acc_cyc_q.push_back(cyc);
    end
    if (req_hs) begin
      if (m_rw) m_busy = 0;
      else m_issued = 1;
    end
    if (rsp_cap) begin
      m_captured = 1; m_rdata = out_rsp_data; m_rtag = out_rsp_tag;
    end
    if (rsp_hs) begin
      m_busy = 0; rsp_hs_cyc = cyc; n_rsp++; rsp_seen = 0;
    end
    m_armed = 1;
  endtask

  task automatic step();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst_n = 1;
    m_ptr = '0; m_owner = '0; m_armed = 0; m_busy = 0; m_issued = 0; m_captured = 0;
    acc_q.delete(); acc_cyc_q.delete();
    rsp_seen = 0; n_rsp = 0; req_valid_cnt = 0; rsp_valid_cnt = 0;
  endtask

  task automatic set_req(input logic [1:0] r, input bit rw, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [DW-1:0] d);
    in_req_rw[r] = rw;
    in_req_addr[r] = a;
    in_req_tag[r] = t;
    in_req_data[r] = d;
    in_req_byteen[r] = 16'($urandom);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_random();
    for (int r = 0; r < 4; r++) begin
      in_req_valid[r] = ($urandom_range(0, 99) < 60);
      set_req(2'(r), 1'($urandom), AW'($urandom), TW'($urandom), rand_data());
    end
    out_req_ready = ($urandom_range(0, 99) < 70);
    out_rsp_valid = ($urandom_range(0, 99) < 40);
    out_rsp_data  = rand_data();
    out_rsp_tag   = TW'($urandom);
    in_rsp_ready  = 4'($urandom);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wcnt;
    do_reset();

    // Four requesters writing back to back: grants 0,1,2,3,0 every other cycle.
    for (int r = 0; r < 4; r++) set_req(2'(r), 1'b1, AW'(32'h100 + r), TW'(r), rand_data());
    in_req_valid = 4'b1111;
    out_req_ready = 1;
    repeat (11) step();
    check_eq("t1_nacc", acc_q.size() >= 5, 1);
    if (acc_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check_eq("t1_grant", acc_q[k], k % 4);
        if (k > 0) check_eq("t1_gap", acc_cyc_q[k] - acc_cyc_q[k-1], 2);
      end
    end
    in_req_valid = 0;
    repeat (3) step();

    // Read from requester 2 with a response three WAIT cycles late.
    do_reset();
    set_req(2'd2, 1'b0, AW'(32'h0001234), 8'h5A, rand_data());
    in_req_valid = 4'b0100;
    in_rsp_ready = 4'b0100;
    out_req_ready = 1;
    out_rsp_valid = 0;
    wcnt = 0;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      if (acc_q.size() > 0) in_req_valid = 0;
      if (obs_rsp_ready) wcnt++;
      if (m_captured) out_rsp_valid = 0;
      else if (wcnt == 3) begin
        out_rsp_valid = 1;
        out_rsp_data = {96'h0123456789abcdef01234567, 32'hDEADBEEF};
        out_rsp_tag = 8'h5A;
      end
      if (n_rsp > 0) ok = 1;
    end
    check_eq("t2_done", ok, 1);
    check_eq("t2_onehot", last_rsp_valid, 4'b0100);
    if (acc_cyc_q.size() > 0) check_eq("t2_latency", rsp_first_cyc - acc_cyc_q[0], 6);
    step();

    // Write held by serializer backpressure for five cycles.
    do_reset();
    set_req(2'd0, 1'b1, AW'(32'h3aa55), 8'h11, rand_data());
    set_req(2'd1, 1'b1, AW'(32'h1beef), 8'h22, rand_data());
    in_req_valid = 4'b0011;
    out_req_ready = 0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      if (acc_q.size() > 0) ok = 1;
    end
    check_eq("t3_accept", ok, 1);
    req_valid_cnt = 0;
    repeat (5) step();
    out_req_ready = 1;
    step();
    step();
    check_eq("t3_held_cycles", req_valid_cnt, 6);
    check_eq("t3_nacc", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check_eq("t3_second", acc_q[1], 1);
      check_eq("t3_gap", acc_cyc_q[1] - acc_cyc_q[0], 7);
    end
    in_req_valid = 0;
    repeat (2) step();

    // Pointer at 3 with requesters 1 and 3 pending: 3 first, then 1, then pointer 2.
    do_reset();
    for (int r = 0; r < 4; r++) set_req(2'(r), 1'b1, AW'($urandom), TW'($urandom), rand_data());
    in_req_valid = 4'b0100;
    out_req_ready = 1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      if (acc_q.size() > 0) ok = 1;
    end
    check_eq("t4_first", ok, 1);
    in_req_valid = 0;
    step();
    in_req_valid = 4'b1010;
    repeat (4) step();
    in_req_valid = 4'b1111;
    step();
    check_eq("t4_nacc", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check_eq("t4_g1", acc_q[1], 3);
      check_eq("t4_g2", acc_q[2], 1);
      check_eq("t4_g3", acc_q[3], 2);
    end
    in_req_valid = 0;
    repeat (2) step();

    // Owner 1 stalls its response for four cycles while requester 0 waits.
    do_reset();
    set_req(2'd1, 1'b0, AW'(32'h2222), 8'h33, rand_data());
    set_req(2'd0, 1'b1, AW'(32'h0444), 8'h44, rand_data());
    in_req_valid = 4'b0010;
    in_rsp_ready = 4'b1101;
    out_req_ready = 1;
    out_rsp_valid = 1;
    out_rsp_data = rand_data();
    out_rsp_tag = 8'h33;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      if (acc_q.size() > 0) ok = 1;
    end
    in_req_valid = 4'b0001;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      if (m_captured) ok = 1;
    end
    check_eq("t5_captured", ok, 1);
    out_rsp_valid = 0;
    rsp_valid_cnt = 0;
    repeat (4) step();
    in_rsp_ready = 4'b1111;
    step();
    step();
    check_eq("t5_rsp_cycles", rsp_valid_cnt, 5);
    check_eq("t5_nacc", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check_eq("t5_next", acc_q[1], 0);
      check_eq("t5_gap", acc_cyc_q[1] - rsp_hs_cyc, 1);
    end
    in_req_valid = 0;
    repeat (2) step();

    // Reset while waiting for a read response; late response must be ignored.
    do_reset();
    set_req(2'd0, 1'b0, AW'(32'h5555), 8'h66, rand_data());
    in_req_valid = 4'b0001;
    out_req_ready = 1;
    out_rsp_valid = 0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      if (obs_rsp_ready) ok = 1;
    end
    check_eq("t6_in_wait", ok, 1);
    for (int r = 0; r < 4; r++) set_req(2'(r), 1'b1, AW'($urandom), TW'($urandom), rand_data());
    in_req_valid = 4'b1111;
    out_rsp_valid = 1;
    do_reset();
    repeat (4) step();
    check_eq("t6_nacc", acc_q.size() > 0, 1);
    if (acc_q.size() > 0) check_eq("t6_first_grant", acc_q[0], 0);
    out_rsp_valid = 0;
    in_req_valid = 0;
    repeat (2) step();

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      step();
    end
    check_eq("rand_progress", n_rsp > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
